// File: rtl/reduce_serial_pkg.sv
// Shared types and constants for the bit-serial reduction block.
package reduce_pkg;

    // Control states: waiting for an operand, consuming chunks, holding a result
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Values the six result outputs take while in reset
    localparam logic RST_AND  = 1'b0;
    localparam logic RST_OR   = 1'b0;
    localparam logic RST_XOR  = 1'b0;
    localparam logic RST_NAND = 1'b1;
    localparam logic RST_NOR  = 1'b1;
    localparam logic RST_XNOR = 1'b1;

endpackage : reduce_pkg

// File: rtl/reduce_serial_chunk.sv
// Combinational AND/OR/XOR reduction of one BPC-bit slice of the operand.
module reduce_chunk #(
    parameter int BPC = 1
) (
    input  logic [BPC-1:0] i_chunk,
    output logic           o_and,
    output logic           o_or,
    output logic           o_xor
);

    assign o_and = &i_chunk;
    assign o_or  = |i_chunk;
    assign o_xor = ^i_chunk;

endmodule : reduce_chunk

// File: rtl/reduce_serial.sv
// Bit-serial &, |, ^ (and complements) of a WIDTH-bit operand, BPC bits per
// cycle, with a valid/ready operand input and a registered valid/ready result.
module reduce_serial
    import reduce_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BPC   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             o_and,
    output logic             o_or,
    output logic             o_xor,
    output logic             o_nand,
    output logic             o_nor,
    output logic             o_xnor
);

    localparam int NCH = WIDTH / BPC;
    localparam int CW  = $clog2(NCH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NCH - 1);

    generate
        if (WIDTH < 2 || BPC < 1 || (WIDTH % BPC) != 0) begin : g_bad_param
            $error("reduce_serial: WIDTH must be >= 2 and divisible by BPC");
        end
    endgenerate

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic             r_acc_and;
    logic             r_acc_or;
    logic             r_acc_xor;
    logic             r_out_valid;
    logic             r_and;
    logic             r_or;
    logic             r_xor;
    logic             r_nand;
    logic             r_nor;
    logic             r_xnor;

    logic             w_accept;
    logic             w_last;
    logic             w_chunk_and;
    logic             w_chunk_or;
    logic             w_chunk_xor;
    logic             w_and_nxt;
    logic             w_or_nxt;
    logic             w_xor_nxt;

    // Ready does not look at in_valid, so there is no combinational loop upstream
    assign in_ready = (r_state == IDLE) | ((r_state == HOLD) & out_ready);
    assign w_accept = in_valid & in_ready;
    assign w_last   = (r_state == SHIFT) && (r_cnt == LAST_CNT);

    reduce_chunk #(.BPC(BPC)) u_chunk (
        .i_chunk (r_shift[BPC-1:0]),
        .o_and   (w_chunk_and),
        .o_or    (w_chunk_or),
        .o_xor   (w_chunk_xor)
    );

    assign w_and_nxt = r_acc_and & w_chunk_and;
    assign w_or_nxt  = r_acc_or  | w_chunk_or;
    assign w_xor_nxt = r_acc_xor ^ w_chunk_xor;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; HOLD can hand straight over to SHIFT on a same-cycle accept
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_state_nxt = SHIFT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SHIFT: begin
                if (w_last) begin
                    w_state_nxt = HOLD;
                end else begin
                    w_state_nxt = SHIFT;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (in_valid) begin
                        w_state_nxt = SHIFT;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_state_nxt = HOLD;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand shift register, chunk counter and running accumulators
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift   <= '0;
            r_cnt     <= '0;
            r_acc_and <= 1'b1;
            r_acc_or  <= 1'b0;
            r_acc_xor <= 1'b0;
        end else if (w_accept) begin
            r_shift   <= in_data;
            r_cnt     <= '0;
            r_acc_and <= 1'b1;
            r_acc_or  <= 1'b0;
            r_acc_xor <= 1'b0;
        end else if (r_state == SHIFT) begin
            r_shift   <= r_shift >> BPC;
            r_cnt     <= r_cnt + CW'(1'b1);
            r_acc_and <= w_and_nxt;
            r_acc_or  <= w_or_nxt;
            r_acc_xor <= w_xor_nxt;
        end
    end

    // Result registers: written only on the completing edge, complements written alongside
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_and       <= RST_AND;
            r_or        <= RST_OR;
            r_xor       <= RST_XOR;
            r_nand      <= RST_NAND;
            r_nor       <= RST_NOR;
            r_xnor      <= RST_XNOR;
        end else if (w_last) begin
            r_out_valid <= 1'b1;
            r_and       <= w_and_nxt;
            r_or        <= w_or_nxt;
            r_xor       <= w_xor_nxt;
            r_nand      <= ~w_and_nxt;
            r_nor       <= ~w_or_nxt;
            r_xnor      <= ~w_xor_nxt;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign o_and     = r_and;
    assign o_or      = r_or;
    assign o_xor     = r_xor;
    assign o_nand    = r_nand;
    assign o_nor     = r_nor;
    assign o_xnor    = r_xnor;

endmodule : reduce_serial

// File: tb/tb_reduce_serial.sv
// Directed, table-driven bench for reduce_serial (BPC=1 and BPC=8 builds).
module tb_reduce_serial;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] in_data;
    logic       o_and, o_or, o_xor, o_nand, o_nor, o_xnor;

    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [7:0] b_in_data;
    logic       b_and, b_or, b_xor, b_nand, b_nor, b_xnor;

    int total = 0;
    int bad   = 0;

    localparam logic [5:0] RST_RES = 6'b000111;

    always #5 clk = ~clk;

    reduce_serial #(.WIDTH(8), .BPC(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .o_and(o_and), .o_or(o_or), .o_xor(o_xor),
        .o_nand(o_nand), .o_nor(o_nor), .o_xnor(o_xnor)
    );

    reduce_serial #(.WIDTH(8), .BPC(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .o_and(b_and), .o_or(b_or), .o_xor(b_xor),
        .o_nand(b_nand), .o_nor(b_nor), .o_xnor(b_xnor)
    );

    wire logic [5:0] res  = {o_and, o_or, o_xor, o_nand, o_nor, o_xnor};
    wire logic [5:0] bres = {b_and, b_or, b_xor, b_nand, b_nor, b_xnor};

    typedef struct {
        logic [7:0] x;
        logic [5:0] exp;   // {and, or, xor, nand, nor, xnor}
    } vec_t;

    vec_t vecs[10];

    function automatic logic [5:0] gold(input logic [7:0] x);
        return {&x, |x, ^x, ~&x, ~|x, ~^x};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Offer x at the current negedge, wait for the result; return at the negedge where out_valid is seen.
    task automatic do_op(input logic [7:0] x, input logic [5:0] exp, input string nm);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_accept_timeout"}, 32'(n < 50), 32'd1);
        in_valid = 1'b1;
        in_data  = x;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_latency"}, 32'(n), 32'd8);
        chk({nm, "_result"}, 32'(res), 32'(exp));
    endtask

    initial begin
        logic [5:0] held;
        int         st;

        vecs[0] = '{8'hFF, 6'b110001};
        vecs[1] = '{8'h00, 6'b000111};
        vecs[2] = '{8'h01, 6'b011100};
        vecs[3] = '{8'hA5, 6'b010101};
        vecs[4] = '{8'h7F, 6'b011100};
        vecs[5] = '{8'h80, 6'b011100};
        vecs[6] = '{8'h3C, 6'b010101};
        vecs[7] = '{8'hFE, 6'b011100};
        vecs[8] = '{8'h55, 6'b010101};
        vecs[9] = '{8'h07, 6'b011100};

        rst = 1'b1;
        in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = 8'h00; b_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_outputs", 32'(res), 32'(RST_RES));
        rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        // Table: back-to-back, each next operand handed off in the HOLD cycle
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].x, vecs[i].exp, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_hold_in_ready", i), 32'(in_ready), 32'd1);
        end

        // Exhaustive sweep with random consumer stalls
        for (int x = 0; x < 256; x++) begin
            do_op(8'(x), gold(8'(x)), $sformatf("sweep%0d", x));
            held = res;
            out_ready = 1'b0;
            st = $urandom_range(0, 3);
            for (int s = 0; s < st; s++) begin
                @(negedge clk);
                chk("sweep_stall_valid", 32'(out_valid), 32'd1);
                chk("sweep_stall_stable", 32'(res), 32'(held));
            end
            out_ready = 1'b1;
        end

        // Drain, then a 20-cycle stall on 8'hA5
        @(negedge clk);
        chk("drain_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        do_op(8'hA5, 6'b010101, "stall_a5");
        for (int s = 0; s < 20; s++) begin
            @(negedge clk);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_result", 32'(res), 32'(6'b010101));
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("stall_release_valid", 32'(out_valid), 32'd0);
        chk("stall_release_ready", 32'(in_ready), 32'd1);

        // Reset in the middle of shifting 8'h7F
        in_valid = 1'b1;
        in_data  = 8'h7F;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_outputs", 32'(res), 32'(RST_RES));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        for (int s = 0; s < 12; s++) begin
            @(negedge clk);
            chk("midrst_no_stale_valid", 32'(out_valid), 32'd0);
            chk("midrst_no_stale_out", 32'(res), 32'(RST_RES));
        end
        do_op(8'h3C, 6'b010101, "after_rst");

        // BPC == WIDTH build: one-cycle latency
        @(negedge clk);
        chk("bpc8_in_ready", 32'(b_in_ready), 32'd1);
        b_in_valid = 1'b1;
        b_in_data  = 8'h80;
        @(negedge clk);
        b_in_valid = 1'b0;
        chk("bpc8_not_yet_valid", 32'(b_out_valid), 32'd0);
        @(negedge clk);
        chk("bpc8_valid", 32'(b_out_valid), 32'd1);
        chk("bpc8_result", 32'(bres), 32'(6'b011100));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_reduce_serial
